// File: rtl/y86_dmem_responder_if.sv
// Request/response bus between the Y86 memory stage and its data memory.
// The core drives through master; the responder answers through slave.
interface y86_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/y86_dmem_responder.sv
// Y86 data memory: 8-byte little-endian accesses with fixed latency.
// Define DMEM_B2B_EN to let a new request be accepted in the response cycle.
module y86_dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    y86_dmem_responder_if.slave  bus,
    output logic                 busy
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [7:0]       mem_q [MEM_BYTES];

    logic             accept;
    logic             rsp_hs;
    logic             commit;
    logic             addr_err;
    logic [AW-1:0]    base;
    logic [63:0]      ld_data;

    // Full-width compare so addresses near 2^64 cannot wrap into range.
    assign addr_err = addr_q > LAST_ADDR;
    assign base     = addr_q[AW-1:0];
    assign commit   = (state_q == WAIT) && (cnt_q == '0);
    assign accept   = bus.req_valid && bus.req_ready;
    assign rsp_hs   = bus.rsp_valid && bus.rsp_ready;

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_comb begin
        ld_data = '0;
        for (int i = 0; i < 8; i++) begin
            ld_data[8*i +: 8] = mem_q[base + AW'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; a committed store survives reset.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !addr_err) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[base + AW'(i)] <= wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = addr_err;
                    rdata_d = (wr_q || addr_err) ? 64'd0 : ld_data;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (accept) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                        wr_d    = bus.req_write;
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
            end
            WAIT: begin
                bus.req_ready = 1'b0;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
`ifdef DMEM_B2B_EN
                bus.req_ready = bus.rsp_ready;
`else
                bus.req_ready = 1'b0;
`endif
            end
            default: busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Directed bench for y86_dmem_responder at MEM_BYTES=1024, LATENCY=2.
// Vector table for single accesses plus hand sequences for timing cases.
module tb_y86_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    y86_dmem_responder_if bus ();

    y86_dmem_responder #(
        .MEM_BYTES(1024),
        .LATENCY  (2),
        .CNT_W    (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

`ifdef DMEM_B2B_EN
    localparam int EXP_GAP = 3;
`else
    localparam int EXP_GAP = 4;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        w;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns in the same phase.
    task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output logic er, output int lat);
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = ~a;
        bus.req_wdata = ~d;
        bus.req_write = ~w;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] rd, held;
        logic        er;
        int          lat, guard;
        int          acc [$];

        vecs[0]  = '{"st_10",     1'b1, 64'h10,  64'h1122334455667788, 64'h0, 1'b0};
        vecs[1]  = '{"ld_10",     1'b0, 64'h10,  64'h0, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{"st_18",     1'b1, 64'h18,  64'hA0A1A2A3A4A5A6A7, 64'h0, 1'b0};
        vecs[3]  = '{"ld_11",     1'b0, 64'h11,  64'h0, 64'hA711223344556677, 1'b0};
        vecs[4]  = '{"st_3f8",    1'b1, 64'h3F8, 64'h0102030405060708, 64'h0, 1'b0};
        vecs[5]  = '{"ld_3f8",    1'b0, 64'h3F8, 64'h0, 64'h0102030405060708, 1'b0};
        vecs[6]  = '{"ld_3f9",    1'b0, 64'h3F9, 64'h0, 64'h0, 1'b1};
        vecs[7]  = '{"ld_wrap",   1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 1'b1};
        vecs[8]  = '{"st_3f9",    1'b1, 64'h3F9, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1};
        vecs[9]  = '{"ld_3f8_b",  1'b0, 64'h3F8, 64'h0, 64'h0102030405060708, 1'b0};
        vecs[10] = '{"st_13",     1'b1, 64'h13,  64'h00000000000000EE, 64'h0, 1'b0};
        vecs[11] = '{"ld_10_b",   1'b0, 64'h10,  64'h0, 64'h00000000EE667788, 1'b0};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_rdata",     bus.rsp_rdata,      64'd0);
        chk("rst_err",       64'(bus.rsp_err),   64'd0);

        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"}, 64'(er), 64'(vecs[i].exp_err));
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'd2);
        end

        // rsp_ready already high when rsp_valid rises
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'h3F8;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("early_rdy_wait", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        chk("early_rdy_valid", 64'(bus.rsp_valid), 64'd1);
        chk("early_rdy_rdata", bus.rsp_rdata, 64'h0102030405060708);
        @(posedge clk); #1;
        chk("early_rdy_done", 64'(bus.rsp_valid), 64'd0);
        chk("early_rdy_clr", bus.rsp_rdata, 64'd0);
        bus.rsp_ready = 1'b0;

        // response backpressure with a competing store that must be ignored
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'h10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        guard = 0;
        while (!bus.rsp_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        held = bus.rsp_rdata;
        chk("bp_first", held, 64'h00000000EE667788);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'h10;
        bus.req_wdata = 64'hCAFECAFECAFECAFE;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rdata", bus.rsp_rdata, held);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("bp_rel_valid", 64'(bus.rsp_valid), 64'd0);
        chk("bp_rel_busy",  64'(busy),          64'd0);
        chk("bp_rel_ready", 64'(bus.req_ready), 64'd1);
        txn(1'b0, 64'h10, 64'h0, rd, er, lat);
        chk("bp_no_store", rd, 64'h00000000EE667788);

        // reset pulse during WAIT drops an uncommitted store
        txn(1'b1, 64'h20, 64'h5555AAAA5555AAAA, rd, er, lat);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'h20;
        bus.req_wdata = 64'h00000000DEADBEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("wait_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy",  64'(busy),          64'd0);
        chk("async_rst_ready", 64'(bus.req_ready), 64'd1);
        chk("async_rst_valid", 64'(bus.rsp_valid), 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 64'h20, 64'h0, rd, er, lat);
        chk("rst_drop_store", rd, 64'h5555AAAA5555AAAA);
        chk("rst_drop_err", 64'(er), 64'd0);

        // throughput with req_valid and rsp_ready held high
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'h10;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.req_ready) acc.push_back(c);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.rsp_ready = 1'b0;
        chk("tp_drained", 64'(busy), 64'd0);
        chk("tp_count_ok", 64'(acc.size() >= 3), 64'd1);
        if (acc.size() >= 3) begin
            chk("tp_gap0", 64'(acc[1] - acc[0]), 64'(EXP_GAP));
            chk("tp_gap1", 64'(acc[2] - acc[1]), 64'(EXP_GAP));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
